// File: rtl/gp_engine_pkg.sv
// Shared definitions for the command sequencer: entry field layout,
// command type and error encodings, and the sequencer state enum.
// No logic; imported by gp_cmd_sequencer.
package gp_engine_pkg;

  // Command entry layout (64-bit): {addr[31:2], data[31:0], type[1:0]}
  localparam int ENT_ADDR_MSB = 63;
  localparam int ENT_ADDR_LSB = 34;
  localparam int ENT_DATA_MSB = 33;
  localparam int ENT_DATA_LSB = 2;
  localparam int ENT_TYPE_MSB = 1;
  localparam int ENT_TYPE_LSB = 0;

  // Command types; 2'b10 and 2'b11 are illegal
  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_RWM   = 2'b01;

  // err_code values
  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
  localparam logic [1:0] ERR_MALFORMED = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_CMD,
    S_DECODE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_FETCH_VAL,
    S_WAIT_VAL,
    S_MOD_WR,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/gp_cmd_sequencer.sv
// Purpose: walks a command buffer from entry 0, issuing bus WRITEs and read-modify-writes until an all-zero end marker.
// Latency: fetch returns the cycle after cmd_rd_en; each command takes >= 4 cycles (fetch, wait, decode, bus phase).
// Backpressure: bus requests hold valid/addr/data until mst_i_ready; every wait phase is bounded by TIMEOUT_CYC.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, abort              program control pulses
//   busy, done, err, err_code status (done is a one-cycle pulse, err/err_code sticky until next start)
//   exec_cnt                  completed commands, saturating at 255
//   cmd_rd_en/cmd_addr        command buffer fetch request and entry index
//   cmd_rd_valid/cmd_out      fetched entry
//   mst_o_*/mst_i_*           bus master request and response
module gp_cmd_sequencer
  import gp_engine_pkg::*;
#(
  parameter int CMD_WIDTH   = 64,
  parameter int CMD_DEPTH   = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [7:0]            exec_cnt,
  output logic                  cmd_rd_en,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_rd_valid,
  input  logic [CMD_WIDTH-1:0]  cmd_out,
  output logic                  mst_o_valid,
  output logic [ADDR_WIDTH-1:0] mst_o_addr,
  output logic [DATA_WIDTH-1:0] mst_o_wr_data,
  output logic                  mst_o_rd0_wr1,
  input  logic                  mst_i_ready,
  input  logic [DATA_WIDTH-1:0] mst_i_rd_data,
  input  logic                  mst_i_rd_valid
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH    = ADDR_WIDTH'(CMD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO      = ADDR_WIDTH'(2);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, idx_nxt;
  logic [CMD_WIDTH-1:0]  cmd_reg, cmd_nxt;
  logic [DATA_WIDTH-1:0] rd_reg, rd_nxt;
  logic [DATA_WIDTH-1:0] val_reg, val_nxt;
  logic [7:0]            cnt_nxt;
  logic                  err_nxt;
  logic [1:0]            code_nxt;
  logic [TW-1:0]         tmo_cnt;
  logic                  tmo_hit;
  logic                  in_wait;

  logic [ADDR_WIDTH-1:0] ent_addr;
  logic [DATA_WIDTH-1:0] ent_data;
  logic [1:0]            ent_type;
  logic [DATA_WIDTH-1:0] merged;
  logic [7:0]            cnt_inc;

  // The RWM entry stays in cmd_reg while the value entry is fetched, so its
  // address and mask remain available for the final write.
  assign ent_addr = ADDR_WIDTH'({cmd_reg[ENT_ADDR_MSB:ENT_ADDR_LSB], 2'b00});
  assign ent_data = DATA_WIDTH'(cmd_reg[ENT_DATA_MSB:ENT_DATA_LSB]);
  assign ent_type = cmd_reg[ENT_TYPE_MSB:ENT_TYPE_LSB];
  assign merged   = (rd_reg & ~ent_data) | (val_reg & ent_data);
  assign cnt_inc  = (exec_cnt == 8'hFF) ? exec_cnt : exec_cnt + 8'd1;

  assign in_wait = state inside {S_WAIT_CMD, S_WAIT_VAL, S_WR_REQ,
                                 S_RD_REQ, S_RD_WAIT, S_MOD_WR};
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cmd_nxt   = cmd_reg;
    rd_nxt    = rd_reg;
    val_nxt   = val_reg;
    cnt_nxt   = exec_cnt;
    err_nxt   = err;
    code_nxt  = err_code;

    // Abort wins over start and over a command completing in the same cycle,
    // so nothing else is committed on that edge.
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            idx_nxt   = '0;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            code_nxt  = ERR_NONE;
            state_nxt = S_FETCH;
          end
        end
        S_FETCH: state_nxt = S_WAIT_CMD;
        S_WAIT_CMD: begin
          if (cmd_rd_valid) begin
            cmd_nxt   = cmd_out;
            state_nxt = S_DECODE;
          end else if (tmo_hit) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_TIMEOUT;
          end
        end
        S_DECODE: begin
          if (cmd_reg == '0) begin
            state_nxt = S_DONE;
          end else if (ent_type == CMD_WRITE) begin
            state_nxt = S_WR_REQ;
          end else if (ent_type == CMD_RWM) begin
            // The last entry has no room for the value entry that must follow.
            if (idx == DEPTH - ONE) begin
              state_nxt = S_ERR;
              code_nxt  = ERR_MALFORMED;
            end else begin
              state_nxt = S_RD_REQ;
            end
          end else begin
            state_nxt = S_ERR;
            code_nxt  = ERR_ILLEGAL;
          end
        end
        S_WR_REQ: begin
          if (mst_i_ready) begin
            idx_nxt   = idx + ONE;
            cnt_nxt   = cnt_inc;
            state_nxt = (idx + ONE >= DEPTH) ? S_DONE : S_FETCH;
          end else if (tmo_hit) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_TIMEOUT;
          end
        end
        S_RD_REQ: begin
          if (mst_i_ready) begin
            state_nxt = S_RD_WAIT;
          end else if (tmo_hit) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_TIMEOUT;
          end
        end
        S_RD_WAIT: begin
          if (mst_i_rd_valid) begin
            rd_nxt    = mst_i_rd_data;
            state_nxt = S_FETCH_VAL;
          end else if (tmo_hit) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_TIMEOUT;
          end
        end
        S_FETCH_VAL: state_nxt = S_WAIT_VAL;
        S_WAIT_VAL: begin
          if (cmd_rd_valid) begin
            if (cmd_out[ENT_TYPE_MSB:ENT_TYPE_LSB] == CMD_WRITE) begin
              val_nxt   = DATA_WIDTH'(cmd_out[ENT_DATA_MSB:ENT_DATA_LSB]);
              state_nxt = S_MOD_WR;
            end else begin
              state_nxt = S_ERR;
              code_nxt  = ERR_MALFORMED;
            end
          end else if (tmo_hit) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_TIMEOUT;
          end
        end
        S_MOD_WR: begin
          if (mst_i_ready) begin
            idx_nxt   = idx + TWO;
            cnt_nxt   = cnt_inc;
            state_nxt = (idx + TWO >= DEPTH) ? S_DONE : S_FETCH;
          end else if (tmo_hit) begin
            state_nxt = S_ERR;
            code_nxt  = ERR_TIMEOUT;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        S_ERR:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end

    if (state_nxt == S_ERR) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      cmd_reg  <= '0;
      rd_reg   <= '0;
      val_reg  <= '0;
      exec_cnt <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cmd_reg  <= cmd_nxt;
      rd_reg   <= rd_nxt;
      val_reg  <= val_nxt;
      exec_cnt <= cnt_nxt;
      err      <= err_nxt;
      err_code <= code_nxt;
      // Restart on every state change so each phase gets its own budget.
      if (state_nxt != state)
        tmo_cnt <= '0;
      else if (in_wait && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Outputs decode directly from registered state, so abort or reset drops
  // every request on the following cycle.
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign cmd_rd_en     = (state == S_FETCH) || (state == S_FETCH_VAL);
  assign cmd_addr      = (state == S_FETCH_VAL) ? idx + ONE : idx;
  assign mst_o_valid   = (state == S_WR_REQ) || (state == S_RD_REQ) || (state == S_MOD_WR);
  assign mst_o_rd0_wr1 = (state == S_WR_REQ) || (state == S_MOD_WR);
  assign mst_o_addr    = mst_o_valid ? ent_addr : '0;
  assign mst_o_wr_data = (state == S_WR_REQ) ? ent_data :
                         (state == S_MOD_WR) ? merged   : '0;

endmodule

// File: tb/tb_gp_cmd_sequencer.sv
// Directed bench for gp_cmd_sequencer: command memory and bus slave models
// driven on the falling edge, hand-computed expectations per program.
module tb_gp_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [7:0]  exec_cnt;
  logic        cmd_rd_en;
  logic [31:0] cmd_addr;
  logic        cmd_rd_valid = 1'b0;
  logic [63:0] cmd_out = '0;
  logic        mst_o_valid;
  logic [31:0] mst_o_addr, mst_o_wr_data;
  logic        mst_o_rd0_wr1;
  logic        mst_i_ready = 1'b0;
  logic [31:0] mst_i_rd_data = '0;
  logic        mst_i_rd_valid = 1'b0;

  gp_cmd_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code),
    .exec_cnt      (exec_cnt),
    .cmd_rd_en     (cmd_rd_en),
    .cmd_addr      (cmd_addr),
    .cmd_rd_valid  (cmd_rd_valid),
    .cmd_out       (cmd_out),
    .mst_o_valid   (mst_o_valid),
    .mst_o_addr    (mst_o_addr),
    .mst_o_wr_data (mst_o_wr_data),
    .mst_o_rd0_wr1 (mst_o_rd0_wr1),
    .mst_i_ready   (mst_i_ready),
    .mst_i_rd_data (mst_i_rd_data),
    .mst_i_rd_valid(mst_i_rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // models / logs
  logic [63:0] mem [128];
  logic        fetch_pend = 1'b0;
  logic [6:0]  fetch_addr = '0;
  logic        rd_pend = 1'b0;
  logic        rd_hold = 1'b0;
  logic        rdy_en = 1'b1;
  logic [31:0] rd_resp = '0;
  int          fetch_cnt, rd_acc, req_cyc, done_cnt;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    return {a[31:2], d, t};
  endfunction

  // Falling-edge responders: command data returns one cycle after cmd_rd_en,
  // ready is given in the same cycle a request is seen, read data the cycle after.
  always @(negedge clk) begin
    cmd_rd_valid = fetch_pend;
    cmd_out      = fetch_pend ? mem[fetch_addr] : '0;
    fetch_pend   = cmd_rd_en;
    if (cmd_rd_en) begin
      fetch_addr = cmd_addr[6:0];
      fetch_cnt++;
    end
    mst_i_rd_valid = rd_pend && !rd_hold;
    mst_i_rd_data  = rd_pend ? rd_resp : '0;
    rd_pend        = 1'b0;
    mst_i_ready    = mst_o_valid && rdy_en;
    if (mst_o_valid) req_cyc++;
    if (mst_i_ready) begin
      if (mst_o_rd0_wr1) begin
        wr_addr_q.push_back(mst_o_addr);
        wr_data_q.push_back(mst_o_wr_data);
      end else begin
        rd_acc++;
        rd_pend = 1'b1;
      end
    end
    if (done) done_cnt++;
  end

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = '0;
  endtask

  task automatic clear_log();
    fetch_cnt = 0; rd_acc = 0; req_cyc = 0; done_cnt = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int max_cyc);
    int n;
    clear_log();
    pulse_start();
    n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int wc;
    clear_mem();
    clear_log();

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_err_code", {30'd0, err_code}, 0);
    check("rst_exec_cnt", {24'd0, exec_cnt}, 0);
    check("rst_cmd_rd_en", {31'd0, cmd_rd_en}, 0);
    check("rst_mst_valid", {31'd0, mst_o_valid}, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_mst_addr", mst_o_addr, 0);
    check("rst_mst_wdata", mst_o_wr_data, 0);

    // single WRITE then end marker
    clear_mem();
    mem[0] = mk(32'h100, 32'hA5A5A5A5, 2'b00);
    run_prog("wr", 100);
    check("wr_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check("wr_addr", wr_addr_q[0], 32'h100);
      check("wr_data", wr_data_q[0], 32'hA5A5A5A5);
    end
    check("wr_done", done_cnt, 1);
    check("wr_exec_cnt", {24'd0, exec_cnt}, 1);
    check("wr_err", {31'd0, err}, 0);

    // read-modify-write pair
    clear_mem();
    mem[0] = mk(32'h200, 32'h0000FF00, 2'b01);
    mem[1] = mk(32'h0, 32'h00003400, 2'b00);
    rd_resp = 32'h12345678;
    run_prog("rwm", 100);
    check("rwm_reads", rd_acc, 1);
    check("rwm_wr_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check("rwm_wr_addr", wr_addr_q[0], 32'h200);
      check("rwm_wr_data", wr_data_q[0], 32'h12343478);
    end
    check("rwm_exec_cnt", {24'd0, exec_cnt}, 1);
    check("rwm_done", done_cnt, 1);

    // illegal type
    clear_mem();
    mem[0] = mk(32'h300, 32'h1, 2'b10);
    run_prog("ill", 100);
    check("ill_err", {31'd0, err}, 1);
    check("ill_err_code", {30'd0, err_code}, 1);
    check("ill_bus_req", req_cyc, 0);
    check("ill_done", done_cnt, 0);

    // bus never ready: timeout after TIMEOUT_CYC cycles of request
    clear_mem();
    mem[0] = mk(32'h400, 32'hDEADBEEF, 2'b00);
    rdy_en = 1'b0;
    run_prog("tmo", 400);
    rdy_en = 1'b1;
    check("tmo_err", {31'd0, err}, 1);
    check("tmo_err_code", {30'd0, err_code}, 2);
    check("tmo_valid_cycles", req_cyc, 256);
    check("tmo_valid_dropped", {31'd0, mst_o_valid}, 0);
    check("tmo_writes", wr_addr_q.size(), 0);

    // abort while waiting for read data
    clear_mem();
    mem[0] = mk(32'h200, 32'h0000FF00, 2'b01);
    mem[1] = mk(32'h0, 32'h00003400, 2'b00);
    rd_hold = 1'b1;
    clear_log();
    pulse_start();
    n = 0;
    while (rd_acc == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_read_issued", rd_acc, 1);
    repeat (3) @(negedge clk);
    check("abort_pre_busy", {31'd0, busy}, 1);
    check("abort_pre_valid", {31'd0, mst_o_valid}, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_valid", {31'd0, mst_o_valid}, 0);
    check("abort_cmd_rd_en", {31'd0, cmd_rd_en}, 0);
    rd_hold = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_writes", wr_addr_q.size(), 0);
    check("abort_done", done_cnt, 0);
    check("abort_err", {31'd0, err}, 0);

    // 127 WRITEs then an RWM in the last entry
    clear_mem();
    for (int i = 0; i < 127; i++) mem[i] = mk(32'h1000 + 4 * i, i + 1, 2'b00);
    mem[127] = mk(32'h2000, 32'hFF, 2'b01);
    run_prog("last_rwm", 3000);
    check("last_rwm_err", {31'd0, err}, 1);
    check("last_rwm_err_code", {30'd0, err_code}, 3);
    check("last_rwm_exec_cnt", {24'd0, exec_cnt}, 127);
    check("last_rwm_writes", wr_addr_q.size(), 127);
    check("last_rwm_reads", rd_acc, 0);
    check("last_rwm_done", done_cnt, 0);

    // full buffer of WRITEs, no end marker
    mem[127] = mk(32'h1000 + 4 * 127, 32'd128, 2'b00);
    run_prog("full", 3000);
    check("full_writes", wr_addr_q.size(), 128);
    check("full_exec_cnt", {24'd0, exec_cnt}, 128);
    check("full_done", done_cnt, 1);
    check("full_err", {31'd0, err}, 0);
    check("full_err_code", {30'd0, err_code}, 0);
    check("full_fetches", fetch_cnt, 128);
    if (wr_addr_q.size() == 128) begin
      check("full_last_addr", wr_addr_q[127], 32'h11FC);
      check("full_last_data", wr_data_q[127], 32'd128);
    end

    // reset in the middle of a program
    clear_log();
    pulse_start();
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_valid", {31'd0, mst_o_valid}, 0);
    check("mrst_cmd_rd_en", {31'd0, cmd_rd_en}, 0);
    check("mrst_exec_cnt", {24'd0, exec_cnt}, 0);
    rst = 1'b0;
    wc = wr_addr_q.size();
    n = fetch_cnt;
    repeat (30) @(negedge clk);
    check("mrst_no_writes", wr_addr_q.size(), wc);
    check("mrst_no_fetch", fetch_cnt, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gp_cmd_sequencer.md
GP_CMD_SEQUENCER -- requirements
Module: gp_cmd_sequencer

Interface
REQ-001 SHALL have parameters:
- CMD_WIDTH, 64, command entry width.
- CMD_DEPTH, 128, command buffer entries.
- ADDR_WIDTH, 32, bus and index width.
- DATA_WIDTH, 32, bus data width.
- TIMEOUT_CYC, 256, maximum wait cycles per bus phase.

REQ-002 SHALL have ports (clock and reset first; single clock; reset synchronous, active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse, begin program at entry 0.
- abort  in  1  pulse, stop program.
- busy  out  1  program running.
- done  out  1  one-cycle pulse, program completed.
- err  out  1  sticky error flag.
- err_code  out  2  01 illegal type, 10 timeout, 11 malformed RWM.
- exec_cnt  out  8  commands completed.
- cmd_rd_en  out  1  command fetch request.
- cmd_addr  out  ADDR_WIDTH  entry index.
- cmd_rd_valid  in  1  fetched entry valid.
- cmd_out  in  CMD_WIDTH  fetched entry.
- mst_o_valid  out  1  bus request.
- mst_o_addr  out  ADDR_WIDTH  bus address.
- mst_o_wr_data  out  DATA_WIDTH  bus write data.
- mst_o_rd0_wr1  out  1  1 = write.
- mst_i_ready  in  1  request accepted.
- mst_i_rd_data  in  DATA_WIDTH  read data.
- mst_i_rd_valid  in  1  read data valid.

Function
REQ-003 SHALL decode each entry as: address = {cmd_out[63:34], 2'b00}, data = cmd_out[33:2], type = cmd_out[1:0] (00 WRITE, 01 RWM, 10/11 illegal).
REQ-004 SHALL implement states IDLE, FETCH, WAIT_CMD, DECODE, WR_REQ, RD_REQ, RD_WAIT, FETCH_VAL, WAIT_VAL, MOD_WR, DONE, ERR.
REQ-005 SHALL, in IDLE with start=1 and busy=0, clear index, exec_cnt, err and err_code, then go to FETCH; start while busy=1 SHALL be ignored.
REQ-006 SHALL assert cmd_rd_en for exactly one cycle in FETCH with cmd_addr = index, then wait in WAIT_CMD for cmd_rd_valid (expected the following cycle) and register cmd_out.
REQ-007 SHALL treat an all-zero 64-bit entry as the end marker and go to DONE; done=1 for one cycle, then IDLE.
REQ-008 SHALL, for WRITE, drive mst_o_valid=1, mst_o_rd0_wr1=1, address and data, all held stable until the cycle mst_i_ready=1; the command then completes.
REQ-009 SHALL, for RWM, issue a read (mst_o_rd0_wr1=0) held until mst_i_ready=1, then capture mst_i_rd_data on mst_i_rd_valid, with the RWM data field used as mask.
REQ-010 SHALL, after the RWM read, fetch entry index+1 (FETCH_VAL/WAIT_VAL); its type SHALL be WRITE and its data used as value; otherwise go to ERR with code 11.
REQ-011 SHALL write (rd_data & ~mask) | (value & mask) to the RWM address in MOD_WR; the RWM pair counts as one command and advances index by 2.
REQ-012 SHALL advance index by 1 after each WRITE, and increment exec_cnt (saturating at 255) on each completed command.
REQ-013 SHALL go to DONE without fetching when index reaches CMD_DEPTH; an RWM at CMD_DEPTH-1 (no value entry) SHALL go to ERR with code 11.
REQ-014 SHALL go to ERR with code 01 on an illegal type.
REQ-015 SHALL count wait cycles in WAIT_CMD, WAIT_VAL, WR_REQ, RD_REQ, RD_WAIT and MOD_WR; the counter resets on each state entry, and reaching TIMEOUT_CYC SHALL go to ERR with code 10.
REQ-016 SHALL, in ERR, set err=1, drop mst_o_valid, pulse done=0, and return to IDLE the next cycle; err and err_code SHALL hold until the next accepted start.
REQ-017 SHALL, on abort while busy, deassert mst_o_valid and cmd_rd_en the next cycle and return to IDLE without done or err; abort SHALL take priority over start and completion in the same cycle.
REQ-018 SHALL assert busy in every state except IDLE.

Reset
REQ-019 SHALL, on rst=1 at a clk edge:
- enter IDLE;
- drive busy, done, err, cmd_rd_en and mst_o_valid to 0;
- drive err_code, exec_cnt, cmd_addr, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1 and the timeout counter to 0.
REQ-020 SHALL abandon any in-flight bus or fetch transaction on mid-program reset, with no further requests issued.

Structure
REQ-021 SHALL place the command type encodings (WRITE, RWM), err_code values, state enum and entry field bit positions in a shared package gp_engine_pkg.
REQ-022 SHALL be a single FSM module with no sub-modules; the timeout counter is inline.

Verification
REQ-023 Program: entry0 = WRITE addr 0x100 data 0xA5A5A5A5, entry1 = 0 -> one write to 0x100 with 0xA5A5A5A5, done pulse, exec_cnt=1, err=0.
REQ-024 RWM: entry0 = RWM addr 0x200 mask 0x0000FF00, entry1 = WRITE value 0x00003400, rd_data 0x12345678 -> write 0x12343478 to 0x200, exec_cnt=1.
REQ-025 Entry0 type 10 -> err=1, err_code=01, no bus request, returns to IDLE.
REQ-026 Hold mst_i_ready=0 for 256 cycles on a WRITE -> err_code=10, mst_o_valid drops.
REQ-027 Abort during RD_WAIT -> IDLE next cycle, no MOD_WR write, done=0, err=0.
REQ-028 RWM at entry 127 with all entries non-zero -> err_code=11; then a full 128-WRITE program -> 128 writes, exec_cnt=128, done.
